io_fabric: RTL and testbench
============================

// Module: io_fabric
// PURPOSE
//  Parametrised Wishbone IO decoder, successor to the fixed 10-slot IO controller.
//  Single-master slave port from the CPU bus, fanned out to NSLAVES peripheral slots selected by adr_i[SEL_MSB:SEL_LSB].
//  Adds: per-slot enable mask, bus timeout with err_o, slot-0 local register bank, masked interrupt aggregation.
// PARAMETERS
//  NSLAVES   16             number of slots (slot 0 is local, 1..NSLAVES-1 external); power of 2, 2..16
//  ADDR_W    17             adr_i width
//  SEL_LSB   12             low bit of slot field; field width = clog2(NSLAVES)
//  SLOT_EN   16'hFFFF       bit n=1: slot n populated; unpopulated slot -> error
//  TIMEOUT   255            max BUSY cycles awaiting s_ack_i before error (1..65535)
//  IRQ_W     8              number of interrupt inputs
// PORTS
//  clk_i      in   1              system clock
//  rst_i      in   1              synchronous active-high reset
//  cyc_i      in   1              master cycle
//  stb_i      in   1              master strobe
//  we_i       in   1              master write enable
//  adr_i      in   ADDR_W         word address
//  sel_i      in   4              byte selects
//  dat_i      in   32             write data
//  dat_o      out  32             registered read data
//  ack_o      out  1              one-cycle normal termination
//  err_o      out  1              one-cycle error termination (timeout/unpopulated)
//  m_cyc_o    out  1              cycle to slaves, high only in BUSY
//  m_we_o     out  1              latched we
//  m_adr_o    out  ADDR_W         latched address
//  m_sel_o    out  4              latched sel
//  m_dat_o    out  32             latched write data
//  s_stb_o    out  NSLAVES        one-hot slot strobe, qualified by BUSY
//  s_ack_i    in   NSLAVES        per-slot ack
//  s_dat_i    in   NSLAVES*32     per-slot read data, slot n at [n*32+:32]
//  irq_i      in   IRQ_W          level interrupt sources
//  irq_o      out  1              |(irq_i & irq_mask)
// BEHAVIOUR
//  Reset: state=IDLE; dat_o=0, ack_o=0, err_o=0, m_*=0, s_stb_o=0, irq_mask=0, err_count=0, err_addr=0, timer=0.
//  IDLE: cyc_i&stb_i -> latch adr/we/sel/dat into m_* regs, timer=0, -> BUSY (next cycle).
//  BUSY: m_cyc_o=1, s_stb_o[slot]=1.
//   - slot not in SLOT_EN -> ERR immediately (no strobe issued that cycle).
//   - slot 0: local access, completes -> DONE same cycle.
//   - s_ack_i[slot]: if !we, dat_o<=s_dat_i[slot]; -> DONE. Acks on other slots ignored.
//   - timer==TIMEOUT-1 without ack -> ERR; timer saturates, no wrap.
//   - cyc_i deasserted -> abort to IDLE, no ack/err, dat_o unchanged.
//  DONE: ack_o=1 for exactly one cycle -> IDLE. Writes leave dat_o unchanged.
//  ERR: err_o=1 for one cycle; err_count+=1 (saturates at 32'hFFFFFFFF); err_addr<=m_adr_o; -> IDLE.
//  ack_o and err_o never both high; at most one of s_stb_o set.
//  Total read latency, populated slot acking in BUSY cycle k: ack_o at k+1; local slot: 3 cycles from stb_i.
//  Slot 0 registers (m_adr_o[1:0]); writes honour sel_i per byte:
//   0 irq_mask  RW [IRQ_W-1:0]
//   1 irq_pend  RO irq_i & irq_mask; writes ignored
//   2 err_count RW; any write clears to 0
//   3 err_addr  RO, zero-extended
//  Simultaneous ERR increment and err_count clear: clear wins.
//  irq_o combinational from registered irq_mask; reset mid-transfer -> IDLE, no ack.
// STRUCTURE
//  io_fabric_defs.vh: state encodings (IDLE/BUSY/DONE/ERR), local register offsets.
//  Sub-module io_fabric_regs: slot-0 bank (irq_mask, err_count, err_addr, read mux).
//  Top: FSM, request latch, slot decode, timeout counter, read mux.
// TESTING
//  1 read slot 3, s_ack_i[3] in 2nd BUSY cycle, s_dat_i slot 3=32'hCAFEF00D -> dat_o=CAFEF00D, one ack_o pulse.
//  2 SLOT_EN=16'h00FF, access slot 9 -> err_o one cycle, s_stb_o stays 0, err_count=1, err_addr=adr.
//  3 TIMEOUT=8, slot 2 never acks -> err_o on cycle after 8th BUSY cycle; next transfer to slot 1 acks normally.
//  4 write slot 0 reg 0 = 32'h05 sel=4'h1, irq_i=8'h04 -> irq_o=1, read reg 1 = 32'h4; irq_i=8'h02 -> irq_o=0.
//  5 drop cyc_i during BUSY on slot 5 -> no ack_o/err_o, returns IDLE, err_count unchanged.
//  6 rst_i asserted mid-BUSY -> all outputs 0 next cycle; irq_mask=0, err_count=0.

Source files
------------

// File: rtl/io_fabric_pkg.sv
// io_fabric_pkg: shared state encoding, slot-0 register offsets and helpers for the IO fabric.
package io_fabric_pkg;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } fabric_state_t;

    // Word offsets of the local register bank living in slot 0
    localparam logic [1:0] REG_IRQ_MASK  = 2'd0;
    localparam logic [1:0] REG_IRQ_PEND  = 2'd1;
    localparam logic [1:0] REG_ERR_COUNT = 2'd2;
    localparam logic [1:0] REG_ERR_ADDR  = 2'd3;

    // Saturating increment so the error counter sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/io_fabric_regs.sv
// io_fabric_regs: slot-0 local register bank (interrupt mask, error counter, last error address).
module io_fabric_regs
    import io_fabric_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int IRQ_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        reg_addr,
    input  logic [IRQ_W-1:0]  bit_we,
    input  logic [IRQ_W-1:0]  wr_data,
    input  logic [IRQ_W-1:0]  irq,
    input  logic              err_inc,
    input  logic [ADDR_W-1:0] err_addr_in,
    output logic [31:0]       rd_data,
    output logic              irq_out
);

    logic [IRQ_W-1:0]  irq_mask;
    logic [IRQ_W-1:0]  irq_pend;
    logic [31:0]       err_count;
    logic [ADDR_W-1:0] err_addr;

    assign irq_pend = irq & irq_mask;
    assign irq_out  = |irq_pend;

    // Interrupt mask: only bits whose byte lane is selected take the new value
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_mask <= '0;
        end else if (wr_en && reg_addr == REG_IRQ_MASK) begin
            irq_mask <= (irq_mask & ~bit_we) | (wr_data & bit_we);
        end
    end

    // Error counter: a write of any value clears it, and that clear beats a concurrent increment
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (wr_en && reg_addr == REG_ERR_COUNT) begin
            err_count <= '0;
        end else if (err_inc) begin
            err_count <= sat_inc32(err_count);
        end
    end

    // Capture the address of the transfer that just failed
    always_ff @(posedge clk) begin
        if (rst) begin
            err_addr <= '0;
        end else if (err_inc) begin
            err_addr <= err_addr_in;
        end
    end

    // Read mux, narrower registers zero-extended to the bus width
    always_comb begin
        rd_data = '0;
        case (reg_addr)
            REG_IRQ_MASK:  rd_data = 32'(irq_mask);
            REG_IRQ_PEND:  rd_data = 32'(irq_pend);
            REG_ERR_COUNT: rd_data = err_count;
            REG_ERR_ADDR:  rd_data = 32'(err_addr);
            default:       rd_data = '0;
        endcase
    end

endmodule

// File: rtl/io_fabric.sv
// io_fabric: Wishbone IO decoder fanning one CPU slave port out to NSLAVES peripheral slots,
// with unpopulated-slot and timeout errors, a local slot-0 register bank and masked IRQ aggregation.
module io_fabric
    import io_fabric_pkg::*;
#(
    parameter int          NSLAVES = 16,
    parameter int          ADDR_W  = 17,
    parameter int          SEL_LSB = 12,
    parameter logic [15:0] SLOT_EN = 16'hFFFF,
    parameter int          TIMEOUT = 255,
    parameter int          IRQ_W   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     adr_i,
    input  logic [3:0]            sel_i,
    input  logic [31:0]           dat_i,
    output logic [31:0]           dat_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  m_cyc_o,
    output logic                  m_we_o,
    output logic [ADDR_W-1:0]     m_adr_o,
    output logic [3:0]            m_sel_o,
    output logic [31:0]           m_dat_o,
    output logic [NSLAVES-1:0]    s_stb_o,
    input  logic [NSLAVES-1:0]    s_ack_i,
    input  logic [NSLAVES*32-1:0] s_dat_i,
    input  logic [IRQ_W-1:0]      irq_i,
    output logic                  irq_o
);

    localparam int                 SEL_W      = $clog2(NSLAVES);
    localparam logic [NSLAVES-1:0] SLOT_MASK  = SLOT_EN[NSLAVES-1:0];
    localparam logic [15:0]        TIMER_LAST = 16'(TIMEOUT - 1);

    fabric_state_t    state;
    fabric_state_t    state_next;
    logic [15:0]      timer;
    logic [SEL_W-1:0] slot;
    logic             slot_populated;
    logic             slot_local;
    logic             slot_ack;
    logic [31:0]      slot_dat [NSLAVES];
    logic             local_wr;
    logic             load_dat;
    logic [31:0]      load_val;
    logic [31:0]      local_rd;
    logic [IRQ_W-1:0] mask_bit_we;

    // Slot decode works on the latched address so it is stable for the whole BUSY phase
    assign slot           = m_adr_o[SEL_LSB +: SEL_W];
    assign slot_populated = SLOT_MASK[slot];
    assign slot_local     = (slot == '0);
    assign slot_ack       = s_ack_i[slot];

    for (genvar n = 0; n < NSLAVES; n++) begin : g_slot_dat
        assign slot_dat[n] = s_dat_i[n*32 +: 32];
    end

    for (genvar i = 0; i < IRQ_W; i++) begin : g_mask_we
        assign mask_bit_we[i] = m_sel_o[i/8];
    end

    assign m_cyc_o = (state == ST_BUSY);
    assign ack_o   = (state == ST_DONE);
    assign err_o   = (state == ST_ERR);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus per-cycle completion controls; a dropped master cycle overrides everything
    always_comb begin
        state_next = state;
        local_wr   = 1'b0;
        load_dat   = 1'b0;
        load_val   = slot_dat[slot];
        case (state)
            ST_IDLE: begin
                if (cyc_i && stb_i) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!cyc_i) begin
                    state_next = ST_IDLE;
                end else if (!slot_populated) begin
                    state_next = ST_ERR;
                end else if (slot_local) begin
                    state_next = ST_DONE;
                    local_wr   = m_we_o;
                    load_dat   = !m_we_o;
                    load_val   = local_rd;
                end else if (slot_ack) begin
                    state_next = ST_DONE;
                    load_dat   = !m_we_o;
                end else if (timer >= TIMER_LAST) begin
                    state_next = ST_ERR;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // One-hot strobe to the addressed slot, never driven toward an unpopulated slot
    always_comb begin
        s_stb_o = '0;
        if (state == ST_BUSY && slot_populated) begin
            s_stb_o[slot] = 1'b1;
        end
    end

    // Request latch: capture the master's request when a new transfer starts
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_we_o  <= 1'b0;
            m_adr_o <= '0;
            m_sel_o <= '0;
            m_dat_o <= '0;
        end else if (state == ST_IDLE && cyc_i && stb_i) begin
            m_we_o  <= we_i;
            m_adr_o <= adr_i;
            m_sel_o <= sel_i;
            m_dat_o <= dat_i;
        end
    end

    // Timeout counter: counts BUSY cycles, cleared outside BUSY, saturates rather than wrapping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer <= '0;
        end else if (state != ST_BUSY) begin
            timer <= '0;
        end else if (timer != 16'hFFFF) begin
            timer <= timer + 16'd1;
        end
    end

    // Read data register: only updated by a completing read, so writes and errors leave it alone
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dat_o <= '0;
        end else if (load_dat) begin
            dat_o <= load_val;
        end
    end

    io_fabric_regs #(
        .ADDR_W (ADDR_W),
        .IRQ_W  (IRQ_W)
    ) u_regs (
        .clk         (clk_i),
        .rst         (rst_i),
        .wr_en       (local_wr),
        .reg_addr    (m_adr_o[1:0]),
        .bit_we      (mask_bit_we),
        .wr_data     (m_dat_o[IRQ_W-1:0]),
        .irq         (irq_i),
        .err_inc     (err_o),
        .err_addr_in (m_adr_o),
        .rd_data     (local_rd),
        .irq_out     (irq_o)
    );

endmodule

// File: tb/tb_io_fabric.sv
// tb_io_fabric: directed table plus randomized transfers for io_fabric, checked against a cycle-count reference model.
module tb_io_fabric;

    localparam logic [15:0] SLOT_EN_TB = 16'h00FF;
    localparam int          TIMEOUT_TB = 8;
    localparam int          WINDOW     = 12;
    localparam int          KIND_ABORT = 0;
    localparam int          KIND_ACK   = 1;
    localparam int          KIND_ERR   = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cyc_i;
    logic          stb_i;
    logic          we_i;
    logic [16:0]   adr_i;
    logic [3:0]    sel_i;
    logic [31:0]   dat_i;
    logic [31:0]   dat_o;
    logic          ack_o;
    logic          err_o;
    logic          m_cyc_o;
    logic          m_we_o;
    logic [16:0]   m_adr_o;
    logic [3:0]    m_sel_o;
    logic [31:0]   m_dat_o;
    logic [15:0]   s_stb_o;
    logic [15:0]   s_ack_i;
    logic [511:0]  s_dat_i;
    logic [7:0]    irq_i;
    logic          irq_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0]  mdl_mask;
    logic [31:0] mdl_errcnt;
    logic [16:0] mdl_erraddr;
    logic [31:0] mdl_dat;

    typedef struct {
        logic        we;
        logic [16:0] adr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          ack_at;
        int          drop_at;
        logic [31:0] sdat;
        logic [7:0]  irq;
        int          exp_ack;
        int          exp_err;
        logic [31:0] exp_dat;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [21];

    io_fabric #(
        .NSLAVES (16),
        .ADDR_W  (17),
        .SEL_LSB (12),
        .SLOT_EN (SLOT_EN_TB),
        .TIMEOUT (TIMEOUT_TB),
        .IRQ_W   (8)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cyc_i   (cyc_i),
        .stb_i   (stb_i),
        .we_i    (we_i),
        .adr_i   (adr_i),
        .sel_i   (sel_i),
        .dat_i   (dat_i),
        .dat_o   (dat_o),
        .ack_o   (ack_o),
        .err_o   (err_o),
        .m_cyc_o (m_cyc_o),
        .m_we_o  (m_we_o),
        .m_adr_o (m_adr_o),
        .m_sel_o (m_sel_o),
        .m_dat_o (m_dat_o),
        .s_stb_o (s_stb_o),
        .s_ack_i (s_ack_i),
        .s_dat_i (s_dat_i),
        .irq_i   (irq_i),
        .irq_o   (irq_o)
    );

    // Free-running clock
    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic we, input logic [16:0] adr, input logic [31:0] wdata,
                                input logic [3:0] sel, input int ack_at, input int drop_at,
                                input logic [31:0] sdat, input logic [7:0] irq, input int exp_ack,
                                input int exp_err, input logic [31:0] exp_dat, input logic exp_irq);
        vec_t v;
        v.we = we; v.adr = adr; v.wdata = wdata; v.sel = sel; v.ack_at = ack_at; v.drop_at = drop_at;
        v.sdat = sdat; v.irq = irq; v.exp_ack = exp_ack; v.exp_err = exp_err; v.exp_dat = exp_dat;
        v.exp_irq = exp_irq;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Last BUSY cycle (1-based) and outcome of a transfer, from the bus rules alone
    task automatic predict(input int slot, input int ack_at, input int drop_at, output int kind, output int last_busy);
        int natural_end;
        int natural_kind;
        if (!SLOT_EN_TB[slot]) begin
            natural_end = 1; natural_kind = KIND_ERR;
        end else if (slot == 0) begin
            natural_end = 1; natural_kind = KIND_ACK;
        end else if (ack_at >= 1 && ack_at <= TIMEOUT_TB) begin
            natural_end = ack_at; natural_kind = KIND_ACK;
        end else begin
            natural_end = TIMEOUT_TB; natural_kind = KIND_ERR;
        end
        if (drop_at >= 1 && drop_at <= natural_end) begin
            kind = KIND_ABORT; last_busy = drop_at;
        end else begin
            kind = natural_kind; last_busy = natural_end;
        end
    endtask

    function automatic logic [31:0] model_local_read(input logic [1:0] r, input logic [7:0] irq);
        case (r)
            2'd0:    return {24'h0, mdl_mask};
            2'd1:    return {24'h0, irq & mdl_mask};
            2'd2:    return mdl_errcnt;
            default: return {15'h0, mdl_erraddr};
        endcase
    endfunction

    task automatic run_xfer(input logic wr, input logic [16:0] adr, input logic [31:0] wdata,
                            input logic [3:0] sel, input int ack_at, input int drop_at,
                            input int stray_at, input int stray_slot, input logic [7:0] irq,
                            input int exp_last, input logic [15:0] exp_stb,
                            output int ack_cyc, output int err_cyc, output int n_ack,
                            output int n_err, output int trace_bad, output int both_bad);
        int slot;
        logic [15:0] acks;
        slot = int'(adr[15:12]);
        ack_cyc = -1; err_cyc = -1; n_ack = 0; n_err = 0; trace_bad = 0; both_bad = 0;
        @(negedge clk_i);
        irq_i = irq; we_i = wr; adr_i = adr; sel_i = sel; dat_i = wdata;
        s_ack_i = '0; cyc_i = 1'b1; stb_i = 1'b1;
        for (int c = 1; c <= WINDOW; c++) begin
            @(posedge clk_i);
            #1;
            if (ack_o) begin n_ack++; if (ack_cyc < 0) ack_cyc = c; end
            if (err_o) begin n_err++; if (err_cyc < 0) err_cyc = c; end
            if (ack_o && err_o) both_bad++;
            if (c <= exp_last) begin
                if (m_cyc_o !== 1'b1 || s_stb_o !== exp_stb) trace_bad++;
            end else begin
                if (m_cyc_o !== 1'b0 || s_stb_o !== 16'h0) trace_bad++;
            end
            acks = '0;
            if (c == ack_at) acks[slot] = 1'b1;
            if (c == stray_at) acks[stray_slot] = 1'b1;
            s_ack_i = acks;
            if (ack_o || err_o || c == drop_at) begin
                cyc_i = 1'b0; stb_i = 1'b0;
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0; s_ack_i = '0;
    endtask

    // One transfer, checked against the reference model, which is then advanced
    task automatic apply_stimulus(input string tag, input logic wr, input logic [16:0] adr,
                                  input logic [31:0] wdata, input logic [3:0] sel, input int ack_at,
                                  input int drop_at, input int stray_at, input logic [31:0] sdat,
                                  input logic [7:0] irq, output int ack_cyc, output int err_cyc);
        int slot, kind, last, stray_slot, n_ack, n_err, tr_bad, bo_bad;
        logic [15:0] exp_stb;
        slot = int'(adr[15:12]);
        for (int n = 0; n < 16; n++) s_dat_i[n*32 +: 32] = $urandom();
        s_dat_i[slot*32 +: 32] = sdat;
        stray_slot = (slot + 1 + int'($urandom_range(0, 14))) % 16;
        predict(slot, ack_at, drop_at, kind, last);
        exp_stb = SLOT_EN_TB[slot] ? (16'h1 << slot) : 16'h0;
        run_xfer(wr, adr, wdata, sel, ack_at, drop_at, stray_at, stray_slot, irq, last, exp_stb,
                 ack_cyc, err_cyc, n_ack, n_err, tr_bad, bo_bad);
        if (kind == KIND_ACK) begin
            if (slot == 0) begin
                if (!wr) mdl_dat = model_local_read(adr[1:0], irq);
                else if (adr[1:0] == 2'd0 && sel[0]) mdl_mask = wdata[7:0];
                else if (adr[1:0] == 2'd2) mdl_errcnt = 32'h0;
            end else if (!wr) begin
                mdl_dat = sdat;
            end
        end else if (kind == KIND_ERR) begin
            if (mdl_errcnt != 32'hFFFF_FFFF) mdl_errcnt = mdl_errcnt + 32'd1;
            mdl_erraddr = adr;
        end
        check_output({tag, " ack_cycle"}, 32'(ack_cyc), (kind == KIND_ACK) ? 32'(last + 1) : 32'hFFFF_FFFF);
        check_output({tag, " err_cycle"}, 32'(err_cyc), (kind == KIND_ERR) ? 32'(last + 1) : 32'hFFFF_FFFF);
        check_output({tag, " ack_pulses"}, 32'(n_ack), (kind == KIND_ACK) ? 32'd1 : 32'd0);
        check_output({tag, " err_pulses"}, 32'(n_err), (kind == KIND_ERR) ? 32'd1 : 32'd0);
        check_output({tag, " cyc_stb_trace"}, 32'(tr_bad), 32'd0);
        check_output({tag, " ack_err_overlap"}, 32'(bo_bad), 32'd0);
        check_output({tag, " dat_o"}, dat_o, mdl_dat);
        check_output({tag, " irq_o"}, 32'(irq_o), 32'(|(irq & mdl_mask)));
    endtask

    task automatic model_reset();
        mdl_mask = '0; mdl_errcnt = '0; mdl_erraddr = '0; mdl_dat = '0;
    endtask

    initial begin
        int ack_cyc, err_cyc;
        logic        r_we;
        logic [16:0] r_adr;
        int          r_ack, r_drop, r_stray;

        // Directed vectors; state carries from row to row
        tbl[0]  = mk(1'b0, 17'h03010, 32'h0,        4'hF, 2, 0, 32'hCAFEF00D, 8'h00,  3, -1, 32'hCAFEF00D, 1'b0);
        tbl[1]  = mk(1'b0, 17'h09ABC, 32'h0,        4'hF, 1, 0, 32'h12345678, 8'h00, -1,  2, 32'hCAFEF00D, 1'b0);
        tbl[2]  = mk(1'b0, 17'h00002, 32'h0,        4'hF, 0, 0, 32'h0,        8'h00,  2, -1, 32'h00000001, 1'b0);
        tbl[3]  = mk(1'b0, 17'h00003, 32'h0,        4'hF, 0, 0, 32'h0,        8'h00,  2, -1, 32'h00009ABC, 1'b0);
        tbl[4]  = mk(1'b0, 17'h02000, 32'h0,        4'hF, 0, 0, 32'h55555555, 8'h00, -1,  9, 32'h00009ABC, 1'b0);
        tbl[5]  = mk(1'b0, 17'h01000, 32'h0,        4'hF, 1, 0, 32'h11112222, 8'h00,  2, -1, 32'h11112222, 1'b0);
        tbl[6]  = mk(1'b1, 17'h00000, 32'h05,       4'h1, 0, 0, 32'h0,        8'h04,  2, -1, 32'h11112222, 1'b1);
        tbl[7]  = mk(1'b0, 17'h00001, 32'h0,        4'hF, 0, 0, 32'h0,        8'h04,  2, -1, 32'h00000004, 1'b1);
        tbl[8]  = mk(1'b0, 17'h00001, 32'h0,        4'hF, 0, 0, 32'h0,        8'h02,  2, -1, 32'h00000000, 1'b0);
        tbl[9]  = mk(1'b0, 17'h05000, 32'h0,        4'hF, 0, 2, 32'h66666666, 8'h02, -1, -1, 32'h00000000, 1'b0);
        tbl[10] = mk(1'b0, 17'h00002, 32'h0,        4'hF, 0, 0, 32'h0,        8'h02,  2, -1, 32'h00000002, 1'b0);
        tbl[11] = mk(1'b1, 17'h00002, 32'hDEADBEEF, 4'h0, 0, 0, 32'h0,        8'h02,  2, -1, 32'h00000002, 1'b0);
        tbl[12] = mk(1'b0, 17'h00002, 32'h0,        4'hF, 0, 0, 32'h0,        8'h02,  2, -1, 32'h00000000, 1'b0);
        tbl[13] = mk(1'b0, 17'h04000, 32'h0,        4'hF, 8, 0, 32'hA5A50001, 8'h02,  9, -1, 32'hA5A50001, 1'b0);
        tbl[14] = mk(1'b1, 17'h00000, 32'hFF,       4'h0, 0, 0, 32'h0,        8'h02,  2, -1, 32'hA5A50001, 1'b0);
        tbl[15] = mk(1'b0, 17'h00000, 32'h0,        4'hF, 0, 0, 32'h0,        8'h02,  2, -1, 32'h00000005, 1'b0);
        tbl[16] = mk(1'b1, 17'h03000, 32'h77,       4'hF, 1, 0, 32'h0,        8'h02,  2, -1, 32'h00000005, 1'b0);
        tbl[17] = mk(1'b0, 17'h07000, 32'h0,        4'hF, 7, 0, 32'h00007777, 8'h02,  8, -1, 32'h00007777, 1'b0);
        tbl[18] = mk(1'b1, 17'h00001, 32'hFFFFFFFF, 4'hF, 0, 0, 32'h0,        8'h00,  2, -1, 32'h00007777, 1'b0);
        tbl[19] = mk(1'b0, 17'h00001, 32'h0,        4'hF, 0, 0, 32'h0,        8'hFF,  2, -1, 32'h00000005, 1'b1);
        tbl[20] = mk(1'b0, 17'h00003, 32'h0,        4'hF, 0, 0, 32'h0,        8'hFF,  2, -1, 32'h00002000, 1'b1);

        rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = '0; sel_i = '0; dat_i = '0;
        s_ack_i = '0; s_dat_i = '0; irq_i = '0;
        model_reset();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_output("reset ack_err_cyc", {29'h0, ack_o, err_o, m_cyc_o}, 32'h0);
        check_output("reset s_stb_o", 32'(s_stb_o), 32'h0);
        check_output("reset dat_o", dat_o, 32'h0);
        check_output("reset m_adr_we_sel", {10'h0, m_adr_o, m_we_o, m_sel_o}, 32'h0);
        check_output("reset m_dat_o", m_dat_o, 32'h0);
        rst_i = 1'b0;

        $display("[TB] directed table");
        for (int i = 0; i < 21; i++) begin
            apply_stimulus($sformatf("row%0d", i), tbl[i].we, tbl[i].adr, tbl[i].wdata, tbl[i].sel,
                           tbl[i].ack_at, tbl[i].drop_at, 0, tbl[i].sdat, tbl[i].irq, ack_cyc, err_cyc);
            check_output($sformatf("row%0d tbl_ack", i), 32'(ack_cyc), 32'(tbl[i].exp_ack));
            check_output($sformatf("row%0d tbl_err", i), 32'(err_cyc), 32'(tbl[i].exp_err));
            check_output($sformatf("row%0d tbl_dat", i), dat_o, tbl[i].exp_dat);
            check_output($sformatf("row%0d tbl_irq", i), 32'(irq_o), 32'(tbl[i].exp_irq));
        end

        $display("[TB] randomized transfers");
        for (int i = 0; i < 150; i++) begin
            r_we  = 1'($urandom());
            r_adr = 17'($urandom());
            r_adr[15:12] = 4'($urandom_range(0, 15));
            r_ack = int'($urandom_range(0, 10));
            r_drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 9)) : 0;
            r_stray = int'($urandom_range(0, 10));
            apply_stimulus($sformatf("rnd%0d", i), r_we, r_adr, $urandom(), 4'($urandom()),
                           r_ack, r_drop, r_stray, $urandom(), 8'($urandom()), ack_cyc, err_cyc);
        end

        $display("[TB] reset during BUSY");
        apply_stimulus("pre_rst mask", 1'b1, 17'h00000, 32'hFF, 4'h1, 0, 0, 0, 32'h0, 8'hFF, ack_cyc, err_cyc);
        apply_stimulus("pre_rst err", 1'b0, 17'h0C000, 32'h0, 4'hF, 0, 0, 0, 32'h0, 8'hFF, ack_cyc, err_cyc);
        apply_stimulus("pre_rst read", 1'b0, 17'h06000, 32'h0, 4'hF, 1, 0, 0, 32'h600DF00D, 8'hFF, ack_cyc, err_cyc);
        @(negedge clk_i);
        irq_i = 8'hFF; we_i = 1'b1; adr_i = 17'h13004; sel_i = 4'hF; dat_i = 32'h12345678;
        s_ack_i = '0; cyc_i = 1'b1; stb_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_output("midrst ack_err_cyc", {29'h0, ack_o, err_o, m_cyc_o}, 32'h0);
        check_output("midrst s_stb_o", 32'(s_stb_o), 32'h0);
        check_output("midrst dat_o", dat_o, 32'h0);
        check_output("midrst m_adr_we_sel", {10'h0, m_adr_o, m_we_o, m_sel_o}, 32'h0);
        check_output("midrst m_dat_o", m_dat_o, 32'h0);
        check_output("midrst irq_o", 32'(irq_o), 32'h0);
        @(negedge clk_i);
        cyc_i = 1'b0; stb_i = 1'b0; rst_i = 1'b0;
        model_reset();
        apply_stimulus("post_rst mask", 1'b0, 17'h00000, 32'h0, 4'hF, 0, 0, 0, 32'h0, 8'hFF, ack_cyc, err_cyc);
        check_output("post_rst mask value", dat_o, 32'h0);
        apply_stimulus("post_rst errcnt", 1'b0, 17'h00002, 32'h0, 4'hF, 0, 0, 0, 32'h0, 8'hFF, ack_cyc, err_cyc);
        check_output("post_rst errcnt value", dat_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
